// File: rtl/shift_register_piso.sv
// -----------------------------------------------------------------------------
// shift_register_piso
// Parallel-in, serial-out transmitter. Words arrive through a valid/ready
// handshake into a one-word holding buffer. From there they are moved into the
// shift register and streamed out LSB-first, one bit per `advance`. The buffer
// is refilled while a word is shifting, so that consecutive words leave
// without an idle bit between them.
// All outputs are driven directly from flops. `load_ready` never depends
// combinationally on `advance` or `load_valid`.
// -----------------------------------------------------------------------------
module shift_register_piso #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             advance,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] sreg_r;
   logic [CW-1:0]    bitcnt_r;
   logic [WIDTH-1:0] hold_r;
   logic             hold_full_r;

   logic             load_ready_r;
   logic             serial_out_r;
   logic             serial_valid_r;
   logic             word_done_r;
   logic             busy_r;

   logic             accept_s;
   logic             last_s;

   // A word is taken whenever the buffer is empty. `load_ready_r` mirrors
   // !hold_full_r, so this never couples `advance` into the handshake.
   assign accept_s = load_valid & load_ready_r;

   // The final bit of the current word is being consumed on this edge.
   assign last_s   = (state_r == ST_SHIFT) & advance & (bitcnt_r == LAST_BIT);

   assign load_ready   = load_ready_r;
   assign serial_out   = serial_out_r;
   assign serial_valid = serial_valid_r;
   assign word_done    = word_done_r;
   assign busy         = busy_r;

   // Single FSM process: shifter, holding buffer, bit counter and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         sreg_r         <= {WIDTH{1'b0}};
         bitcnt_r       <= {CW{1'b0}};
         hold_r         <= {WIDTH{1'b0}};
         hold_full_r    <= 1'b0;
         load_ready_r   <= 1'b1;
         serial_out_r   <= 1'b0;
         serial_valid_r <= 1'b0;
         word_done_r    <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         word_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (hold_full_r) begin
                  // Pull the buffered word into the shifter. The buffer was
                  // full, so no accept can coincide with this pull.
                  state_r        <= ST_SHIFT;
                  sreg_r         <= hold_r;
                  bitcnt_r       <= {CW{1'b0}};
                  hold_full_r    <= 1'b0;
                  load_ready_r   <= 1'b1;
                  serial_valid_r <= 1'b1;
                  serial_out_r   <= hold_r[0];
                  busy_r         <= 1'b1;
               end else if (accept_s) begin
                  hold_r         <= load_data;
                  hold_full_r    <= 1'b1;
                  load_ready_r   <= 1'b0;
                  serial_valid_r <= 1'b0;
                  serial_out_r   <= 1'b0;
                  busy_r         <= 1'b1;
               end else begin
                  load_ready_r   <= 1'b1;
                  serial_valid_r <= 1'b0;
                  serial_out_r   <= 1'b0;
                  busy_r         <= 1'b0;
               end
            end

            ST_SHIFT: begin
               if (last_s && hold_full_r) begin
                  // Gapless back-to-back: the next word replaces the finished one.
                  word_done_r    <= 1'b1;
                  sreg_r         <= hold_r;
                  bitcnt_r       <= {CW{1'b0}};
                  hold_full_r    <= 1'b0;
                  load_ready_r   <= 1'b1;
                  serial_valid_r <= 1'b1;
                  serial_out_r   <= hold_r[0];
                  busy_r         <= 1'b1;
               end else if (last_s) begin
                  // Word finished and nothing is waiting. A new word may still
                  // land in the (empty) buffer on this same edge.
                  word_done_r    <= 1'b1;
                  state_r        <= ST_IDLE;
                  sreg_r         <= {WIDTH{1'b0}};
                  bitcnt_r       <= {CW{1'b0}};
                  serial_valid_r <= 1'b0;
                  serial_out_r   <= 1'b0;
                  if (accept_s) begin
                     hold_r       <= load_data;
                     hold_full_r  <= 1'b1;
                     load_ready_r <= 1'b0;
                     busy_r       <= 1'b1;
                  end else begin
                     load_ready_r <= 1'b1;
                     busy_r       <= 1'b0;
                  end
               end else begin
                  if (advance) begin
                     sreg_r       <= {1'b0, sreg_r[WIDTH-1:1]};
                     bitcnt_r     <= bitcnt_r + CNT_ONE;
                     serial_out_r <= sreg_r[1];
                  end else begin
                     // Stall: shifter state and the visible bit hold.
                     serial_out_r <= sreg_r[0];
                  end
                  if (accept_s) begin
                     hold_r       <= load_data;
                     hold_full_r  <= 1'b1;
                     load_ready_r <= 1'b0;
                  end else begin
                     load_ready_r <= ~hold_full_r;
                  end
                  serial_valid_r <= 1'b1;
                  busy_r         <= 1'b1;
               end
            end

            default: begin
               // Unreachable encoding: return to a clean idle state.
               state_r        <= ST_IDLE;
               sreg_r         <= {WIDTH{1'b0}};
               bitcnt_r       <= {CW{1'b0}};
               hold_full_r    <= 1'b0;
               load_ready_r   <= 1'b1;
               serial_valid_r <= 1'b0;
               serial_out_r   <= 1'b0;
               busy_r         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_register_piso.sv
// -----------------------------------------------------------------------------
// tb_shift_register_piso
// Directed bench for the PISO transmitter. A transaction-level model (a queue
// of pending words plus the index of the bit on the wire) predicts every
// output each cycle. A behavioural serial-in receiver reassembles the words,
// and literal expectations pin the bit sequences and the words received.
// -----------------------------------------------------------------------------
module tb_shift_register_piso;

   localparam int W = 8;

   logic         clk        = 1'b0;
   logic         reset_n    = 1'b0;
   logic         load_valid = 1'b0;
   logic [W-1:0] load_data  = 8'h00;
   logic         advance    = 1'b0;
   logic         load_ready;
   logic         serial_out;
   logic         serial_valid;
   logic         word_done;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   shift_register_piso #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_ready   (load_ready),
      .advance      (advance),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .word_done    (word_done),
      .busy         (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // receiver: serial-in shift register, LSB arrives first
   logic [7:0] rx_data = 8'h00;
   always @(posedge clk) begin
      if (serial_valid && advance) rx_data <= {serial_out, rx_data[7:1]};
   end

   // ---------------- transaction model ----------------
   int           m_pos  = -1;
   logic [W-1:0] m_cur  = 8'h00;
   logic [W-1:0] m_pend[$];
   logic         m_done = 1'b0;

   initial begin : model
      bit acc;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_pos  = -1;
            m_done = 1'b0;
            m_pend.delete();
         end else begin
            acc    = load_valid && (m_pend.size() == 0);
            m_done = (m_pos == W-1) && advance;
            if (m_pos < 0) begin
               if (m_pend.size() > 0) begin
                  m_cur = m_pend.pop_front();
                  m_pos = 0;
               end
            end else if (advance) begin
               if (m_pos == W-1) begin
                  if (m_pend.size() > 0) begin
                     m_cur = m_pend.pop_front();
                     m_pos = 0;
                  end else begin
                     m_pos = -1;
                  end
               end else begin
                  m_pos++;
               end
            end
            if (acc) m_pend.push_back(load_data);
         end
      end
   end

   // ---------------- logs gathered by the monitor ----------------
   bit         bit_q[$];
   logic [7:0] rx_q[$];
   int         wd_cyc_q[$];
   int         cons_done_q[$];
   int         run_q[$];
   int         wd_cnt   = 0;
   int         cons_cnt = 0;
   int         run_len  = 0;
   bit         prev_valid = 1'b0;
   bit         prev_adv   = 1'b0;
   bit         prev_out   = 1'b0;

   // compare process + monitor, sampled on the falling edge
   initial begin : monitor
      bit ev, eo, eb, er;
      forever begin
         @(negedge clk);
         if (m_pos >= 0) begin
            ev = 1'b1;
            eo = m_cur[m_pos];
         end else begin
            ev = 1'b0;
            eo = 1'b0;
         end
         eb = ev || (m_pend.size() > 0);
         er = (m_pend.size() == 0);
         chk("serial_valid", serial_valid, ev);
         chk("serial_out", serial_out, eo);
         chk("word_done", word_done, m_done);
         chk("busy", busy, eb);
         chk("load_ready", load_ready, er);

         if (word_done) begin
            wd_cnt++;
            wd_cyc_q.push_back(cyc);
            rx_q.push_back(rx_data);
            cons_done_q.push_back(cons_cnt);
         end
         if (serial_valid && prev_valid && !prev_adv) chk("stall_hold", serial_out, prev_out);
         if (serial_valid && advance) begin
            bit_q.push_back(serial_out);
            cons_cnt++;
         end
         if (serial_valid) begin
            run_len++;
         end else if (run_len > 0) begin
            run_q.push_back(run_len);
            run_len = 0;
         end
         prev_valid = serial_valid;
         prev_adv   = advance;
         prev_out   = serial_out;
      end
   end

   function automatic logic [7:0] rx_at(input int i);
      if (i < rx_q.size()) return rx_q[i];
      else return 8'bxxxx_xxxx;
   endfunction

   function automatic int int_at(input int q[$], input int i);
      if (i < q.size()) return q[i];
      else return -1000;
   endfunction

   task automatic clear_logs();
      bit_q.delete();
      rx_q.delete();
      wd_cyc_q.delete();
      cons_done_q.delete();
      run_q.delete();
      wd_cnt   = 0;
      cons_cnt = 0;
      run_len  = 0;
   endtask

   task automatic wait_wd(input int target, input int budget, input string name);
      for (int i = 0; i < budget && wd_cnt < target; i++) step(1);
      chk(name, wd_cnt, target);
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_serial_valid"}, serial_valid, 1'b0);
      chk({pfx, "_serial_out"}, serial_out, 1'b0);
      chk({pfx, "_word_done"}, word_done, 1'b0);
      chk({pfx, "_busy"}, busy, 1'b0);
      chk({pfx, "_load_ready"}, load_ready, 1'b1);
   endtask

   bit a5_seq[8]     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   bit stall_pat[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // directed stimulus
   initial begin : stim
      step(3);
      check_reset_vals("rst_init");
      reset_n = 1'b1;
      step(1);
      chk("rel_load_ready", load_ready, 1'b1);
      chk("rel_busy", busy, 1'b0);

      // single word A5
      clear_logs();
      advance    = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'hA5;
      step(1);
      load_valid = 1'b0;
      wait_wd(1, 20, "a5_done");
      step(3);
      chk("a5_nbits", bit_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < bit_q.size()) chk($sformatf("a5_bit%0d", i), bit_q[i], a5_seq[i]);
      end
      chk("a5_rx", rx_at(0), 8'hA5);
      chk("a5_wd_count", wd_cnt, 1);

      // stall pattern with 3C
      clear_logs();
      advance    = 1'b0;
      load_valid = 1'b1;
      load_data  = 8'h3C;
      step(1);
      load_valid = 1'b0;
      for (int i = 0; i < 80 && wd_cnt < 1; i++) begin
         advance = stall_pat[i % 4];
         step(1);
      end
      chk("3c_wd", wd_cnt, 1);
      chk("3c_consumes", int_at(cons_done_q, 0), 8);
      chk("3c_rx", rx_at(0), 8'h3C);
      advance = 1'b0;
      step(3);

      // back-to-back FF then 00
      clear_logs();
      advance    = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'hFF;
      step(1);
      load_data  = 8'h00;
      step(2);
      load_valid = 1'b0;
      wait_wd(2, 40, "b2b_done");
      step(3);
      chk("b2b_valid_run", int_at(run_q, 0), 16);
      chk("b2b_wd_spacing", int_at(wd_cyc_q, 1) - int_at(wd_cyc_q, 0), 8);
      chk("b2b_rx0", rx_at(0), 8'hFF);
      chk("b2b_rx1", rx_at(1), 8'h00);

      // backpressure 11, 22, 33 with advance low
      clear_logs();
      advance    = 1'b0;
      load_valid = 1'b1;
      load_data  = 8'h11;
      step(1);
      chk("bp_ready_after1", load_ready, 1'b0);
      chk("bp_busy_after1", busy, 1'b1);
      step(1);
      chk("bp_ready_pull1", load_ready, 1'b1);
      load_data = 8'h22;
      step(1);
      chk("bp_ready_after2", load_ready, 1'b0);
      load_data = 8'h33;
      step(5);
      chk("bp_ready_blocked", load_ready, 1'b0);
      chk("bp_stall_valid", serial_valid, 1'b1);
      chk("bp_stall_bit", serial_out, 1'b1);
      advance = 1'b1;
      for (int i = 0; i < 20 && !load_ready; i++) step(1);
      chk("bp_third_ready", load_ready, 1'b1);
      step(1);
      load_valid = 1'b0;
      chk("bp_third_taken", load_ready, 1'b0);
      wait_wd(3, 40, "bp_done");
      step(12);
      chk("bp_wd_count", wd_cnt, 3);
      chk("bp_rx0", rx_at(0), 8'h11);
      chk("bp_rx1", rx_at(1), 8'h22);
      chk("bp_rx2", rx_at(2), 8'h33);

      // reset mid-word: C3 shifting, 5A buffered
      clear_logs();
      advance    = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'hC3;
      step(1);
      load_data  = 8'h5A;
      step(2);
      load_valid = 1'b0;
      step(2);
      chk("mid_consumes", cons_cnt, 3);
      chk("mid_buffered", load_ready, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      step(2);
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step(1);
         chk("post_rst_valid", serial_valid, 1'b0);
         chk("post_rst_busy", busy, 1'b0);
      end
      chk("post_rst_no_done", wd_cnt, 0);
      chk("post_rst_no_bits", cons_cnt, 3);

      // fresh load after reset
      load_valid = 1'b1;
      load_data  = 8'h96;
      step(1);
      load_valid = 1'b0;
      wait_wd(1, 20, "fresh_done");
      step(2);
      chk("fresh_rx", rx_at(0), 8'h96);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
